// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: round-robin sharing of one CDC edge channel among NumReq coalescing event counters
module edge_event_scheduler #(
  parameter int NumReq = 4,
  parameter int CntWidth = 4,
  parameter int GapCycles = 2,
  parameter int AckTimeout = 64,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_i,
  input  logic [NumReq-1:0]  clr_ovf_i,
  input  logic               ack_i,
  output logic               edge_o,
  output logic [IdWidth-1:0] id_o,
  output logic               busy_o,
  output logic [NumReq-1:0]  pending_o,
  output logic [NumReq-1:0]  overflow_o,
  output logic               timeout_o
);
  localparam int TMax = AckTimeout > GapCycles ? AckTimeout : GapCycles;
  localparam int TW = $clog2(TMax + 1);
  localparam logic [CntWidth-1:0] CntMax = '1;
  typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, GAP} state_t;
  state_t state;
  logic [CntWidth-1:0] cnt [NumReq];
  logic [TW-1:0] tcnt;
  logic [IdWidth-1:0] ptr, gnt;
  logic [IdWidth:0] off, sum;
  logic [2*NumReq-1:0] dbl;
  logic [NumReq-1:0] rot, dec, sat;
  always_comb begin
    pending_o = '0;
    dec = '0;
    sat = '0;
    for (int k = 0; k < NumReq; k++) begin
      pending_o[k] = cnt[k] != '0;
      dec[k] = edge_o && id_o == IdWidth'(k);
      sat[k] = req_i[k] && !dec[k] && cnt[k] == CntMax;
    end
  end
  // rotate pending so the search starts at ptr, then map the offset back
  always_comb begin
    dbl = {pending_o, pending_o} >> ptr;
    rot = dbl[NumReq-1:0];
    off = '0;
    for (int i = NumReq - 1; i >= 0; i--) off = rot[i] ? (IdWidth+1)'(i) : off;
    sum = {1'b0, ptr} + off;
    gnt = sum >= (IdWidth+1)'(NumReq) ? IdWidth'(sum - (IdWidth+1)'(NumReq)) : sum[IdWidth-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= '0;
      for (int k = 0; k < NumReq; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        cnt[k] <= sat[k] || req_i[k] == dec[k] ? cnt[k] : req_i[k] ? cnt[k] + 1'b1 : cnt[k] - 1'b1;
        overflow_o[k] <= sat[k] || (overflow_o[k] && !clr_ovf_i[k]);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      id_o <= '0;
      edge_o <= 1'b0;
      busy_o <= 1'b0;
      timeout_o <= 1'b0;
      tcnt <= '0;
    end else begin
      edge_o <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: if (|pending_o) begin
          state <= FIRE;
          id_o <= gnt;
          ptr <= gnt == IdWidth'(NumReq - 1) ? '0 : gnt + 1'b1;
          edge_o <= 1'b1;
          busy_o <= 1'b1;
        end
        FIRE: begin
          state <= WAIT_ACK;
          tcnt <= '0;
        end
        WAIT_ACK: if (ack_i || tcnt == TW'(AckTimeout - 1)) begin
          state <= GapCycles == 0 ? IDLE : GAP;
          busy_o <= GapCycles != 0;
          timeout_o <= !ack_i;
          tcnt <= '0;
        end else tcnt <= tcnt + 1'b1;
        GAP: if (tcnt == TW'(GapCycles - 1)) begin
          state <= IDLE;
          busy_o <= 1'b0;
        end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_edge_event_scheduler.sv
// tb_edge_event_scheduler: randomized scoreboard bench against a time-based reference model
module tb_edge_event_scheduler;
  localparam int N = 4, GAP = 2, TO = 64, CMAX = 15;
  logic clk = 0, rst = 1, ack = 0;
  logic [3:0] req = 0, clr = 0;
  logic edge_w, busy, timeout;
  logic [1:0] id;
  logic [3:0] pend, ovf;
  always #5 clk = ~clk;
  edge_event_scheduler dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .clr_ovf_i(clr), .ack_i(ack),
    .edge_o(edge_w), .id_o(id), .busy_o(busy), .pending_o(pend),
    .overflow_o(ovf), .timeout_o(timeout)
  );
  typedef struct {int cyc; int id;} ev_t;
  ev_t eq[$];
  int tq[$];
  int ids_seen[$];
  int tests = 0, fails = 0, n = 0;
  int m_cnt[N];
  bit m_ovf[N];
  int m_ptr, m_id, fire_at, idle_from, ack_delay;
  bit waiting, started, exp_busy;
  logic [3:0] exp_pend, exp_ovf;
  int last_edge_cyc, last_edge_id, n_edges, last_to_cyc, n_to;
  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, n, act, exp);
    end
  endfunction
  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end
    m_ptr = 0;
    m_id = 0;
    fire_at = -1;
    idle_from = 0;
    waiting = 0;
  endfunction
  function automatic bit auto_ack();
    return waiting && n > fire_at && ack_delay > 0 && n == fire_at + ack_delay;
  endfunction
  // the model tracks the transfer by cycle numbers: fire cycle, wait window, end of the guard gap
  task automatic step(input bit r, input logic [3:0] q, input bit a, input logic [3:0] c);
    bit in_fire, in_wait, d;
    int k;
    rst = r; req = q; ack = a; clr = c;
    in_fire = fire_at == n;
    in_wait = waiting && n > fire_at;
    exp_busy = in_fire || in_wait || n < idle_from;
    for (int j = 0; j < N; j++) begin
      exp_pend[j] = m_cnt[j] != 0;
      exp_ovf[j] = m_ovf[j];
    end
    started = 1;
    if (r) begin
      model_reset();
      while (eq.size() > 0 && eq[$].cyc > n) void'(eq.pop_back());
      while (tq.size() > 0 && tq[$] > n) void'(tq.pop_back());
    end else begin
      if (!exp_busy && exp_pend != 0) begin
        k = -1;
        for (int i = 0; i < N; i++) if (k < 0 && m_cnt[(m_ptr + i) % N] != 0) k = (m_ptr + i) % N;
        m_id = k;
        m_ptr = (k + 1) % N;
        fire_at = n + 1;
        eq.push_back('{n + 1, k});
      end
      for (int j = 0; j < N; j++) begin
        d = in_fire && j == m_id;
        if (q[j] && !d && m_cnt[j] == CMAX) m_ovf[j] = 1;
        else begin
          m_ovf[j] = m_ovf[j] && !c[j];
          m_cnt[j] = m_cnt[j] + int'(q[j]) - int'(d);
        end
      end
      if (in_fire) waiting = 1;
      else if (in_wait && (a || n - fire_at - 1 == TO - 1)) begin
        if (!a) tq.push_back(n + 1);
        waiting = 0;
        idle_from = n + 1 + GAP;
      end
    end
    @(posedge clk);
    n++;
    #1;
  endtask
  task automatic run(input int cycles);
    repeat (cycles) step(0, 4'b0, auto_ack(), 4'b0);
  endtask
  always @(negedge clk) if (started) begin
    check("busy", int'(busy), int'(exp_busy));
    check("pending", int'(pend), int'(exp_pend));
    check("overflow", int'(ovf), int'(exp_ovf));
    if (edge_w || (eq.size() > 0 && eq[0].cyc <= n)) begin
      if (eq.size() == 0) check("edge_unexpected", int'(edge_w), 0);
      else begin
        ev_t e;
        e = eq.pop_front();
        check("edge_cyc", edge_w ? n : -1, e.cyc);
        check("edge_id", int'(id), e.id);
      end
      if (edge_w) begin
        last_edge_cyc = n;
        last_edge_id = int'(id);
        n_edges++;
        ids_seen.push_back(int'(id));
      end
    end
    if (timeout || (tq.size() > 0 && tq[0] <= n)) begin
      if (tq.size() == 0) check("timeout_unexpected", int'(timeout), 0);
      else check("timeout_cyc", timeout ? n : -1, tq.pop_front());
      if (timeout) begin
        last_to_cyc = n;
        n_to++;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", n);
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, e0, c0;
    int exp3[4] = '{0, 2, 0, 2};
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    ack_delay = 3;
    step(0, 4'b0, 0, 4'b0);
    t0 = n;
    step(0, 4'b0100, 0, 4'b0);
    run(12);
    check("t1_edge_cyc", last_edge_cyc, t0 + 2);
    check("t1_edge_id", last_edge_id, 2);
    check("t1_idle", int'(busy), 0);
    step(1, 4'b0, 0, 4'b0);
    e0 = n_edges;
    ack_delay = 2;
    repeat (3) step(0, 4'b0001, 0, 4'b0);
    run(40);
    check("t2_edges", n_edges - e0, 3);
    step(1, 4'b0, 0, 4'b0);
    ids_seen.delete();
    ack_delay = 1;
    repeat (2) step(0, 4'b0101, 0, 4'b0);
    run(30);
    check("t3_count", ids_seen.size(), 4);
    for (int i = 0; i < 4 && i < ids_seen.size(); i++) check("t3_rr_id", ids_seen[i], exp3[i]);
    step(1, 4'b0, 0, 4'b0);
    ack_delay = -1;
    t0 = n;
    repeat (17) step(0, 4'b0010, 0, 4'b0);
    check("t4_ovf_set", int'(ovf[1]), 1);
    step(0, 4'b0, 0, 4'b0010);
    check("t4_ovf_clr", int'(ovf[1]), 0);
    step(0, 4'b0010, 0, 4'b0010);
    check("t4_ovf_keep", int'(ovf[1]), 1);
    check("t4_pending", int'(pend[1]), 1);
    c0 = n_edges;
    run(90);
    check("t5_to_delay", last_to_cyc - (t0 + 2), TO + 1);
    check("t5_next_served", n_edges - c0, 1);
    check("t5_next_id", last_edge_id, 1);
    ack_delay = 64;
    c0 = n_to;
    run(40);
    check("t5_ack_wins", n_to - c0, 0);
    step(1, 4'b0, 0, 4'b0);
    ack_delay = -1;
    repeat (4) step(0, 4'b0001, 0, 4'b0);
    run(3);
    step(1, 4'b0, 0, 4'b0);
    check("t6_busy", int'(busy), 0);
    check("t6_pending", int'(pend), 0);
    check("t6_edge", int'(edge_w), 0);
    step(0, 4'b0, 1, 4'b0);
    check("t6_ack_ignored", int'(busy), 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int dens;
      logic [3:0] r;
      if (cyc % 150 == 0) begin
        int sel;
        sel = $urandom_range(0, 5);
        ack_delay = sel == 0 ? -1 : sel == 1 ? 64 : sel == 2 ? 63 : $urandom_range(1, 8);
      end
      dens = (cyc / 400) % 3;
      r = 4'($urandom_range(0, 15));
      r = dens == 0 ? r & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) : dens == 1 ? r : 4'b0;
      step($urandom_range(0, 599) == 0, r, auto_ack() | ($urandom_range(0, 19) == 0),
           $urandom_range(0, 9) == 0 ? 4'($urandom_range(0, 15)) : 4'b0);
    end
    run(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
